run_check_ctrl: RTL
===================

Name: run_check_ctrl

Overview:
- Hardware run/check sequencer for the accelerator under test (MyDesign).
- Handshakes `dut_run`/`dut_busy`, measures compute cycles, waits a settle period, then sweeps the output SRAM against a golden SRAM and counts matches.
- Replaces fixed-size, single-round bench sequencing with parametrised widths, runtime result count/base addresses, timeout detection and first-mismatch capture.
- Instantiated beside the input, weight, output and golden `sram` instances. All SRAMs have 1-cycle registered read.

Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 16, SRAM word width.
- CNT_WIDTH, 32, cycle-counter width; counter saturates at all-ones.
- SETTLE_CYCLES, 10, idle cycles between DUT completion and the check sweep.
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN waiting for `dut_busy`=1.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_b  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; begins a round when idle
- num_results  in  ADDR_WIDTH+1  words to compare (0..2^ADDR_WIDTH)
- result_base  in  ADDR_WIDTH  first output-SRAM address checked
- golden_base  in  ADDR_WIDTH  first golden-SRAM address checked
- dut_run  out  1  run request to DUT
- dut_busy  in  1  DUT busy
- res_rd_addr  out  ADDR_WIDTH  output-SRAM read address
- res_rd_data  in  DATA_WIDTH  output-SRAM read data
- gold_rd_addr  out  ADDR_WIDTH  golden-SRAM read address
- gold_rd_data  in  DATA_WIDTH  golden-SRAM read data
- busy  out  1  high from accepted start until done
- done  out  1  1-cycle pulse at end of round
- timeout  out  1  sticky until next start; round aborted
- correct_count  out  ADDR_WIDTH+1  matching words
- compute_cycles  out  CNT_WIDTH  DUT compute cycles
- mismatch  out  1  at least one word differed
- first_mismatch_idx  out  ADDR_WIDTH  index of first differing word

Behaviour:
- Reset (async, reset_b=0):
  - State IDLE.
  - All outputs 0: dut_run, busy, done, timeout, mismatch, correct_count, compute_cycles, first_mismatch_idx, both read addresses.
  - Reset mid-round aborts immediately; dut_run drops asynchronously.
- Start acceptance:
  - start is sampled only in IDLE; it is ignored while busy=1.
  - On acceptance: latch num_results and both bases; clear timeout, mismatch and counts; set busy.
- States and transitions:
  - IDLE: accepted start -> WAIT_IDLE.
  - WAIT_IDLE: wait for dut_busy=0, then -> RUN.
  - RUN: dut_run=1; cycle counter increments each cycle, starting at 1 on the first RUN cycle.
    - First cycle with dut_busy=1 sampled -> COMPUTE; dut_run=0 from the next cycle.
    - TIMEOUT_CYCLES cycles without dut_busy -> set timeout, dut_run=0, -> DONE (no check).
  - COMPUTE: counter keeps incrementing.
    - First cycle with dut_busy=0 sampled: compute_cycles <= counter value; -> SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then -> CHECK.
    - If num_results=0: -> DONE directly, correct_count=0.
  - CHECK: issue one read pair per cycle.
    - Index i = 0..num_results-1.
    - Addresses are (base + i) mod 2^ADDR_WIDTH; wrap-around is legal.
    - Compare result arrives one cycle later; a match increments correct_count.
    - On the first miss: set mismatch and capture first_mismatch_idx = i.
    - After the last issue -> DRAIN.
  - DRAIN: one cycle for the final compare, then -> DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
- Latency: a check of N words takes N+1 cycles (CHECK through DRAIN).
- Output hold: correct_count, compute_cycles, mismatch and first_mismatch_idx hold until the next accepted start.
- Counter saturation: the cycle counter saturates at 2^CNT_WIDTH-1 and never wraps.

Optional Feature:
- Macro: RUN_CHECK_MASK_EN.
- Defined: adds input port `compare_mask` [DATA_WIDTH], latched on start. A word matches when ((res ^ gold) & mask) == 0.
- Undefined: no port; a word matches on exact DATA_WIDTH equality.

Test Plan:
- Basic round: num_results=96, result_base=0x000, golden_base=0x000, golden == result, DUT busy for 200 cycles -> correct_count=96, mismatch=0, compute_cycles=201 (±1 per the defined counting edges), single done pulse.
- Mismatch: num_results=144, result words 5 and 100 corrupted -> correct_count=142, mismatch=1, first_mismatch_idx=5.
- Timeout: DUT never asserts busy, TIMEOUT_CYCLES=16 -> timeout=1 after 16 RUN cycles, dut_run=0, done pulse, correct_count=0.
- Wrap and zero count: result_base=0xFFE, num_results=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001. Then num_results=0 -> done with no CHECK reads, correct_count=0.
- Reset and start while busy: reset_b=0 during CHECK -> all outputs 0 immediately, next start works normally. A start pulse while busy=1 -> ignored.
- Mask (RUN_CHECK_MASK_EN): mask=0xFFF0, all words differ only in bits [3:0], num_results=8 -> correct_count=8.

Source files
------------

// File: rtl/run_check_ctrl_if.sv
// run_check_ctrl_if: DUT run/busy handshake plus the output and golden SRAM read ports.
interface run_check_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  dut_run;
  logic                  dut_busy;
  logic [ADDR_WIDTH-1:0] res_rd_addr;
  logic [DATA_WIDTH-1:0] res_rd_data;
  logic [ADDR_WIDTH-1:0] gold_rd_addr;
  logic [DATA_WIDTH-1:0] gold_rd_data;
  modport master (output dut_run, res_rd_addr, gold_rd_addr, input dut_busy, res_rd_data, gold_rd_data);
  modport slave  (input dut_run, res_rd_addr, gold_rd_addr, output dut_busy, res_rd_data, gold_rd_data);
endinterface

// File: rtl/run_check_ctrl.sv
// run_check_ctrl: runs the accelerator, times its compute phase, then sweeps output vs golden SRAM.
// Define RUN_CHECK_MASK_EN to add a per-bit compare_mask input latched on start.
module run_check_ctrl #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_results,
  input  logic [ADDR_WIDTH-1:0] result_base,
  input  logic [ADDR_WIDTH-1:0] golden_base,
`ifdef RUN_CHECK_MASK_EN
  input  logic [DATA_WIDTH-1:0] compare_mask,
`endif
  run_check_ctrl_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   correct_count,
  output logic [CNT_WIDTH-1:0]  compute_cycles,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] first_mismatch_idx
);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, RUN, COMPUTE, SETTLE, CHECK, DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] SETTLE_LAST = (ADDR_WIDTH+1)'(SETTLE_CYCLES - 1);
  state_t                state, nxt;
  logic [ADDR_WIDTH:0]   n, idx;
  logic [ADDR_WIDTH-1:0] rbase, gbase, cmp_idx;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  cmp_v, hit;
`ifdef RUN_CHECK_MASK_EN
  logic [DATA_WIDTH-1:0] mask;
  assign hit = ((bus.res_rd_data ^ bus.gold_rd_data) & mask) == '0;
`else
  assign hit = bus.res_rd_data == bus.gold_rd_data;
`endif
  // idx doubles as the settle timer and the sweep index
  assign bus.res_rd_addr  = rbase + idx[ADDR_WIDTH-1:0];
  assign bus.gold_rd_addr = gbase + idx[ADDR_WIDTH-1:0];
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.dut_run = state == RUN;
    busy = state != IDLE;
    done = state == DONE;
    case (state)
      IDLE:      nxt = start ? WAIT_IDLE : IDLE;
      WAIT_IDLE: nxt = bus.dut_busy ? WAIT_IDLE : RUN;
      RUN:       nxt = bus.dut_busy ? COMPUTE : (cnt >= CNT_WIDTH'(TIMEOUT_CYCLES)) ? DONE : RUN;
      COMPUTE:   nxt = bus.dut_busy ? COMPUTE : SETTLE;
      SETTLE:    nxt = (idx != SETTLE_LAST) ? SETTLE : (n == '0) ? DONE : CHECK;
      CHECK:     nxt = (idx == n - 1'b1) ? DRAIN : CHECK;
      DRAIN:     nxt = DONE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      n <= '0;
      idx <= '0;
      rbase <= '0;
      gbase <= '0;
      cmp_idx <= '0;
      cmp_v <= 1'b0;
      cnt <= '0;
      timeout <= 1'b0;
      mismatch <= 1'b0;
      correct_count <= '0;
      compute_cycles <= '0;
      first_mismatch_idx <= '0;
`ifdef RUN_CHECK_MASK_EN
      mask <= '0;
`endif
    end else begin
      idx <= ((state == SETTLE || state == CHECK) && nxt == state) ? idx + 1'b1 : '0;
      cmp_v <= state == CHECK;
      cmp_idx <= idx[ADDR_WIDTH-1:0];
      cnt <= (state == WAIT_IDLE) ? CNT_WIDTH'(1) :
             ((state == RUN || state == COMPUTE) && !(&cnt)) ? cnt + 1'b1 : cnt;
      if (state == IDLE && start) begin
        n <= num_results;
        rbase <= result_base;
        gbase <= golden_base;
        timeout <= 1'b0;
        mismatch <= 1'b0;
        correct_count <= '0;
        compute_cycles <= '0;
        first_mismatch_idx <= '0;
`ifdef RUN_CHECK_MASK_EN
        mask <= compare_mask;
`endif
      end
      if (state == RUN && nxt == DONE) timeout <= 1'b1;
      if (state == COMPUTE && !bus.dut_busy) compute_cycles <= cnt;
      if (cmp_v && hit) correct_count <= correct_count + 1'b1;
      if (cmp_v && !hit && !mismatch) begin
        mismatch <= 1'b1;
        first_mismatch_idx <= cmp_idx;
      end
    end
endmodule
